// File: rtl/cond_sub_64_pipe_if.sv
// Streaming operand/result bundle for the pipelined conditional-sum subtractor.
// The master drives operands and output acceptance; the slave is the subtractor.
interface cond_sub_64_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;
  logic             lt_u;
  logic             lt_s;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf, lt_u, lt_s
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf, lt_u, lt_s
  );
endinterface

// File: rtl/cond_sub_64_pipe.sv
// Two-stage valid/ready subtractor: a - b - bin via carry-select slices on a + ~b + ~bin.
// Stage 1 resolves the low half, stage 2 the high half plus all flags.
module cond_sub_64_pipe #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input logic              clk,
  input logic              rst,
  cond_sub_64_pipe_if.slave bus
);
  localparam int HALF   = WIDTH / 2;
  localparam int NSLICE = HALF / SLICE;

  // Each slice computes both carry-in outcomes; the rippling carry only drives the muxes.
  function automatic logic [HALF:0] csel_add(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            cin);
    logic [HALF-1:0] sum;
    logic            c;
    logic [SLICE:0]  r0;
    logic [SLICE:0]  r1;
    sum = '0;
    c   = cin;
    for (int i = 0; i < NSLICE; i++) begin
      r0 = {1'b0, x[i*SLICE +: SLICE]} + {1'b0, y[i*SLICE +: SLICE]};
      r1 = {1'b0, x[i*SLICE +: SLICE]} + {1'b0, y[i*SLICE +: SLICE]} + (SLICE+1)'(1);
      sum[i*SLICE +: SLICE] = c ? r1[SLICE-1:0] : r0[SLICE-1:0];
      c = c ? r1[SLICE] : r0[SLICE];
    end
    return {c, sum};
  endfunction

  logic             s1_valid;
  logic [HALF-1:0]  s1_diff_lo;
  logic             s1_carry;
  logic [HALF-1:0]  s1_a_hi;
  logic [HALF-1:0]  s1_b_hi;

  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, zero_q, ovf_q, lt_u_q, lt_s_q;

  logic             adv1, adv2;
  logic [HALF:0]    lo_sum;
  logic [HALF:0]    hi_sum;
  logic [WIDTH-1:0] full_diff;
  logic             borrow_c;
  logic             ovf_c;

  assign adv2         = !out_valid_q || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1 && !rst;

  assign lo_sum    = csel_add(bus.a[HALF-1:0], ~bus.b[HALF-1:0], ~bus.bin);
  assign hi_sum    = csel_add(s1_a_hi, ~s1_b_hi, s1_carry);
  assign full_diff = {hi_sum[HALF-1:0], s1_diff_lo};
  assign borrow_c  = ~hi_sum[HALF];
  assign ovf_c     = (s1_a_hi[HALF-1] != s1_b_hi[HALF-1]) &&
                     (full_diff[WIDTH-1] != s1_a_hi[HALF-1]);

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so s1 and the output stage can hand off on the same edge without ordering races.
  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too (not only valids) so outputs read 0 after reset.
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_diff_lo <= '0;
      s1_carry   <= 1'b0;
      s1_a_hi    <= '0;
      s1_b_hi    <= '0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_diff_lo <= lo_sum[HALF-1:0];
        s1_carry   <= lo_sum[HALF];
        s1_a_hi    <= bus.a[WIDTH-1:HALF];
        s1_b_hi    <= bus.b[WIDTH-1:HALF];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      lt_u_q      <= 1'b0;
      lt_s_q      <= 1'b0;
    end else if (adv2) begin
      out_valid_q <= s1_valid;
      // A bubble only drops out_valid; the last data stays put.
      if (s1_valid) begin
        diff_q <= full_diff;
        bout_q <= borrow_c;
        zero_q <= (full_diff == '0);
        ovf_q  <= ovf_c;
        lt_u_q <= borrow_c;
        lt_s_q <= full_diff[WIDTH-1] ^ ovf_c;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.lt_u      = lt_u_q;
  assign bus.lt_s      = lt_s_q;
endmodule

// File: tb/tb_cond_sub_64_pipe.sv
// Bench for cond_sub_64_pipe: directed literal vectors plus an arithmetic reference
// model whose expected-result queue is compared against every valid output cycle.
module tb_cond_sub_64_pipe;
  logic clk;
  logic rst;

  cond_sub_64_pipe_if #(.WIDTH(64)) bus ();

  cond_sub_64_pipe #(.WIDTH(64), .SLICE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] diff;
    logic [4:0]  flags;  // {bout, zero, ovf, lt_u, lt_s}
  } res_t;

  res_t exp_q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   stall_in = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference: plain wide arithmetic for the result and borrow, flag rules as defined.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic bin);
    logic [64:0] wide;
    logic        ovf;
    res_t        r;
    wide = {1'b0, a} - {1'b0, b} - {64'd0, bin};
    ovf  = (a[63] != b[63]) && (wide[63] != a[63]);
    r.diff  = wide[63:0];
    r.flags = {wide[64], wide[63:0] == 64'd0, ovf, wide[64], wide[63] ^ ovf};
    return r;
  endfunction

  function automatic logic [4:0] dut_flags();
    return {bus.bout, bus.zero, bus.ovf, bus.lt_u, bus.lt_s};
  endfunction

  // Inputs change 1ns after posedge, so negedge sees the values the next edge will act on.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", bus.out_valid, 64'd0);
      end else begin
        check("stream_diff", bus.diff, exp_q[0].diff);
        check("stream_flags", 64'(dut_flags()), 64'(exp_q[0].flags));
        if (bus.out_ready && !rst) void'(exp_q.pop_front());
      end
    end
    if (rst) exp_q.delete();
    else if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.bin));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pipeline must be empty with out_ready=1; result must show right after the second edge.
  task automatic run_one(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic bin, input logic [63:0] exp_diff, input logic [4:0] exp_flags);
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check({name, "_valid"}, bus.out_valid, 64'd1);
    check({name, "_diff"}, bus.diff, exp_diff);
    check({name, "_flags"}, 64'(dut_flags()), 64'(exp_flags));
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("in_ready_in_reset", bus.in_ready, 64'd0);
    rst = 1'b0;
    #1;
    check("reset_out_valid", bus.out_valid, 64'd0);
    check("reset_diff", bus.diff, 64'd0);
    check("reset_flags", 64'(dut_flags()), 64'd0);
    check("in_ready_after_reset", bus.in_ready, 64'd1);

    run_one("basic",     64'h10, 64'h3, 1'b0, 64'hD, 5'b00000);
    run_one("neg",       64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'b10011);
    run_one("equal",     64'h1234, 64'h1234, 1'b0, 64'h0, 5'b01000);
    run_one("bin_zero",  64'h5, 64'h4, 1'b1, 64'h0, 5'b01000);
    run_one("ovf_neg",   64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 5'b00101);
    run_one("ovf_pos",   64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'h8000_0000_0000_0000, 5'b10110);
    run_one("half_cross", 64'h1_0000_0000, 64'h1, 1'b0, 64'hFFFF_FFFF, 5'b00000);

    // Full-rate stream: in_ready must never drop.
    for (int i = 0; i < 100; i++) begin
      bus.a        = {$urandom, $urandom};
      bus.b        = {$urandom, $urandom};
      bus.bin      = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1;
      if (!bus.in_ready) stall_in++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("stream_no_stall", 64'(stall_in), 64'd0);
    tick();
    tick();
    tick();
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    // Random backpressure and bubbles; half the beats use small operands near the boundaries.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        bus.a = 64'($urandom_range(0, 3)) << (32 * $urandom_range(0, 1));
        bus.b = 64'($urandom_range(0, 3));
      end else begin
        bus.a = {$urandom, $urandom};
        bus.b = {$urandom, $urandom};
      end
      bus.bin = 1'($urandom_range(0, 1));
      tick();
    end

    // Downstream blocked: both stages fill and in_ready must fall.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("full_in_ready", bus.in_ready, 64'd0);
    check("full_out_valid", bus.out_valid, 64'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Two beats in flight, then a one-cycle reset discards them.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 64'hDEAD;
    bus.b         = 64'h1;
    tick();
    bus.a = 64'hBEEF;
    tick();
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 64'd0);
    tick();
    rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 64'd0);
    check("rst_diff", bus.diff, 64'd0);
    check("rst_flags", 64'(dut_flags()), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("rst_no_stale", bus.out_valid, 64'd0);
    run_one("post_rst", 64'h100, 64'hFF, 1'b1, 64'h0, 5'b01000);
    tick();
    tick();
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/cond_sub_64_pipe.md
Name: cond_sub_64_pipe

Overview:
- 64-bit subtractor/comparator. It is the subtract-side counterpart of the team's registered 64-bit conditional-sum adder.
- Computes a - b - bin and produces borrow, zero, signed-overflow and compare flags.
- Two-stage pipeline with a valid/ready handshake on both sides, so it can sit in a streaming datapath under backpressure.
- Internally uses 8-bit carry-select slices on a + ~b + ~bin. Stage 1 resolves the low half; stage 2 resolves the high half.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of 16.
- SLICE, 8, carry-select slice width; must divide WIDTH/2.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- bin  in  1  borrow in
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result this cycle
- diff  out  WIDTH  (a - b - bin) mod 2^WIDTH
- bout  out  1  borrow out: 1 iff a < b + bin (unsigned)
- zero  out  1  diff == 0
- ovf  out  1  signed overflow
- lt_u  out  1  unsigned less-than, equal to bout
- lt_s  out  1  signed less-than, diff[MSB] ^ ovf

Behaviour:
- Arithmetic:
  - Carry-in to the low slice is ~bin. Carry out of the top slice is ~bout.
  - Each slice precomputes both carry-in cases and selects on the incoming carry.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - Flags are computed from the full result and registered with diff in the same beat.
- Input acceptance: a beat is accepted at the rising edge where in_valid && in_ready.
- Stage 1 register (s1):
  - Captures low-half diff and the low-half carry.
  - Captures a and b high halves unmodified, plus s1_valid.
- Stage 2 / output register:
  - Computes the high half from s1 using the registered carry.
  - Loads diff, bout, zero, ovf, lt_u, lt_s and out_valid.
- Latency:
  - Beat accepted at edge T has out_valid=1 and its result visible immediately after edge T+1, provided out_ready was not low.
  - Throughput is one beat per cycle.
- Backpressure:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 && !rst (combinational).
- Stall rules:
  - When adv2=0, output registers hold and s1 holds.
  - When adv1=0, no new beat is captured.
  - No beat is dropped or duplicated.
  - Output data and flags are stable while out_valid && !out_ready.
- Bubbles: if s1_valid=0 and adv2=1, out_valid clears on the next edge after the current output is consumed.
- Reset:
  - In the reset cycle, s1_valid=0 and out_valid=0.
  - diff=0, bout=0, zero=0, ovf=0, lt_u=0, lt_s=0, and s1 data=0.
  - Reset mid-operation discards all in-flight beats.
  - in_ready=0 while rst=1.
- Simultaneous events:
  - Output consumed and new s1 beat advancing on the same edge: output replaced, no gap.
  - Input accepted while s1 advances on the same edge: s1 replaced.

Test Plan:
- a=0x10, b=0x3, bin=0, out_ready=1 -> 2 edges later: diff=0xD, bout=0, zero=0, ovf=0, lt_u=0, lt_s=0.
- a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, lt_u=1, lt_s=1, ovf=0. Then a=b=0x1234, bin=0 -> diff=0, zero=1. Then a=5, b=4, bin=1 -> diff=0, zero=1, bout=0.
- a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, lt_s=1, lt_u=0. a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF -> diff=0x8000_0000_0000_0000, ovf=1, lt_s=0, bout=1.
- Carry crossing the half boundary: a=0x1_0000_0000, b=1 -> diff=0xFFFF_FFFF. Stream 100 random beats with in_valid=1 and out_ready=1 -> one result per cycle, in order, all match the golden model.
- Random out_ready (50%) and random in_valid -> results match in order, no loss or duplication, outputs stable while stalled. Hold out_ready=0 -> in_ready falls once both stages are full.
- Assert rst for one cycle with 2 beats in flight -> out_valid=0 and all outputs 0 next cycle, in_ready=0 during rst, no stale beats emerge afterwards. A fresh beat after reset completes with 2-edge latency.
